layer_output_packer: RTL and testbench
======================================

Name: layer_output_packer

Overview:
- Downstream stage of neuron_processor in the BNN fully-connected classifier.
- Collects the PARALLEL_NEURONS binarised neuron outputs produced per out_valid beat into a full-layer activation vector of NUM_NEURONS bits.
- Once the layer is complete, streams the vector to the next layer PARALLEL_INPUTS bits per beat over a valid/ready handshake.
- Single buffer: filling and draining never overlap; in_ready provides backpressure to the layer controller.

Parameters:
- NUM_NEURONS, 8, neurons in the producing layer (total activation bits). Must be a multiple of PARALLEL_NEURONS and of PARALLEL_INPUTS.
- PARALLEL_NEURONS, 2, activation bits accepted per input beat.
- PARALLEL_INPUTS, 4, activation bits emitted per output beat (next layer's input width).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  in_data carries PARALLEL_NEURONS neuron outputs (driven from neuron_processor out_valid)
- in_data  input  PARALLEL_NEURONS  neuron outputs; bit i belongs to neuron (group_base + i)
- in_ready  output  1  block can accept an input beat
- out_valid  output  1  out_data holds a valid activation slice
- out_ready  input  1  downstream accepts the current beat
- out_data  output  PARALLEL_INPUTS  activation slice; bit j = activation (beat_index*PARALLEL_INPUTS + j)
- out_last  output  1  current beat is the final slice of the layer
- layer_done  output  1  one-cycle pulse on the final output handshake

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset state: FILL; fill counter and drain counter = 0; out_valid = 0, out_last = 0, layer_done = 0. in_ready = 0 while rst is high and 1 from the first cycle after rst deasserts. Buffer contents are not reset. out_data is unspecified whenever out_valid = 0.
- Input accept: an input is accepted when in_valid && in_ready.
- FILL state:
  - in_ready = 1, out_valid = 0.
  - On accept, buffer[fill_cnt +: PARALLEL_NEURONS] <= in_data and fill_cnt += PARALLEL_NEURONS.
  - in_valid gaps of any length are allowed and leave the state unchanged.
- FILL → DRAIN: the cycle after the accept that makes fill_cnt reach NUM_NEURONS. fill_cnt clears to 0.
  - Latency from the last input accept to out_valid = 1 is exactly 1 cycle.
- DRAIN state:
  - in_ready = 0. in_valid is ignored and the buffer is unchanged.
  - out_valid = 1 and out_data = buffer[drain_cnt +: PARALLEL_INPUTS].
  - out_last = 1 when drain_cnt = NUM_NEURONS - PARALLEL_INPUTS.
  - On out_valid && out_ready, drain_cnt += PARALLEL_INPUTS.
  - While out_ready = 0, out_data, out_valid and out_last hold stable (AXI-style: valid never drops before its handshake).
- DRAIN → FILL: on the handshake with out_last = 1.
  - layer_done pulses in that same cycle.
  - The next cycle has out_valid = 0 and in_ready = 1, and drain_cnt = 0.
  - A new layer can begin accepting immediately, giving one bubble cycle between layers.
- Counter widths: $clog2(NUM_NEURONS+1) bits. Counters never wrap past NUM_NEURONS, because the state change occurs exactly at the boundary.
- Degenerate cases:
  - NUM_NEURONS = PARALLEL_NEURONS: one input beat fills the layer.
  - NUM_NEURONS = PARALLEL_INPUTS: a single output beat with out_last = 1.
- Reset mid-operation, in either state: all partial progress is discarded, the block returns to the reset state, and no out_valid is asserted for the aborted layer.
- Elaboration assertions: flag NUM_NEURONS % PARALLEL_NEURONS != 0 or NUM_NEURONS % PARALLEL_INPUTS != 0 as an error.

Test Plan:
- Basic pack (defaults): inputs 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles, out_ready = 1 → buffer 8'h39. out_valid rises 1 cycle after the 4th accept. Beats are 4'h9 (out_last = 0) then 4'h3 (out_last = 1). layer_done pulses with the second beat. in_ready = 1 the following cycle.
- Input gaps: same data with in_valid low for 2 cycles between each beat → identical output 4'h9, 4'h3. in_ready stays 1 throughout FILL.
- Output backpressure: after the fill, hold out_ready = 0 for 3 cycles → out_valid = 1 and out_data = 4'h9 stable for 3 cycles. The first beat is accepted on the cycle out_ready rises.
- Input during DRAIN: drive in_valid = 1, in_data = 2'b11 while draining with out_ready = 0 → in_ready = 0, beats remain 4'h9 and 4'h3. The next layer's contents are unaffected by the ignored data.
- Reset mid-fill: accept 2'b11, 2'b11, assert rst for 1 cycle, then feed 2'b00, 2'b00, 2'b00, 2'b01 → output beats 4'h0 and 4'h4. No out_valid before the 4th post-reset accept.
- Back-to-back layers: layer A data → 8'h39, then immediately layer B → 8'hC6 (inputs 2'b10, 2'b01, 2'b00, 2'b11) with out_ready = 1. Beats are 4'h9, 4'h3, 4'h6, 4'hC, with exactly one layer_done per layer.

Source files
------------

// File: rtl/layer_output_packer.sv
// layer_output_packer
//   Collects PARALLEL_NEURONS binarised neuron outputs per input beat into a
//   NUM_NEURONS-bit activation vector. Once the vector is complete, it streams
//   the vector to the next layer PARALLEL_INPUTS bits per beat over valid/ready.
//   There is a single buffer, so filling and draining never overlap.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   in_valid   : in_data carries PARALLEL_NEURONS neuron outputs
//   in_data    : neuron outputs, bit i -> neuron (group_base + i)
//   in_ready   : block can accept an input beat (FILL state, not in reset)
//   out_valid  : out_data holds a valid activation slice (DRAIN state)
//   out_ready  : downstream accepts the current beat
//   out_data   : activation slice, bit j -> activation (beat*PARALLEL_INPUTS + j)
//   out_last   : current beat is the final slice of the layer
//   layer_done : one-cycle pulse on the final output handshake
module layer_output_packer #(
    parameter int NUM_NEURONS      = 8,
    parameter int PARALLEL_NEURONS = 2,
    parameter int PARALLEL_INPUTS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [PARALLEL_NEURONS-1:0] in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PARALLEL_INPUTS-1:0]  out_data,
    output logic                        out_last,
    output logic                        layer_done
);

    localparam int CW       = $clog2(NUM_NEURONS + 1);
    localparam int N_GROUPS = NUM_NEURONS / PARALLEL_NEURONS;
    localparam int N_BEATS  = NUM_NEURONS / PARALLEL_INPUTS;

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    if ((NUM_NEURONS % PARALLEL_NEURONS) != 0) begin : g_chk_pn
        $error("NUM_NEURONS must be a multiple of PARALLEL_NEURONS");
    end
    if ((NUM_NEURONS % PARALLEL_INPUTS) != 0) begin : g_chk_pi
        $error("NUM_NEURONS must be a multiple of PARALLEL_INPUTS");
    end

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [NUM_NEURONS-1:0] buf_q, buf_d;
    logic                   in_acc;
    logic                   out_hs;

    // Handshake outputs are gated by rst so that a reset arriving in DRAIN
    // suppresses out_valid for the aborted layer in the same cycle.
    assign in_ready   = (state_q == S_FILL) && !rst;
    assign out_valid  = (state_q == S_DRAIN) && !rst;
    assign out_last   = out_valid && (drain_cnt_q == CW'(NUM_NEURONS - PARALLEL_INPUTS));
    assign in_acc     = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign layer_done = out_hs && out_last;

    // Slice mux: the drain counter only ever holds multiples of
    // PARALLEL_INPUTS, so compare against each legal beat offset.
    always_comb begin
        out_data = '0;
        for (int b = 0; b < N_BEATS; b++) begin
            if (drain_cnt_q == CW'(b * PARALLEL_INPUTS)) begin
                out_data = buf_q[b*PARALLEL_INPUTS +: PARALLEL_INPUTS];
            end
        end
    end

    // Buffer write: the slot selected by fill_cnt_q takes in_data on accept.
    always_comb begin
        buf_d = buf_q;
        if (in_acc) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                if (fill_cnt_q == CW'(g * PARALLEL_NEURONS)) begin
                    buf_d[g*PARALLEL_NEURONS +: PARALLEL_NEURONS] = in_data;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_FILL: begin
                if (in_acc) begin
                    if (fill_cnt_q == CW'(NUM_NEURONS - PARALLEL_NEURONS)) begin
                        fill_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + CW'(PARALLEL_NEURONS);
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (out_last) begin
                        drain_cnt_d = '0;
                        state_d     = S_FILL;
                    end else begin
                        drain_cnt_d = drain_cnt_q + CW'(PARALLEL_INPUTS);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Activation storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_layer_output_packer.sv
module tb_layer_output_packer;

    localparam int NN = 8;
    localparam int PN = 2;
    localparam int PI = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PN-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [PI-1:0] out_data;
    logic          out_last;
    logic          layer_done;

    layer_output_packer #(
        .NUM_NEURONS(NN), .PARALLEL_NEURONS(PN), .PARALLEL_INPUTS(PI)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int layers_exp = 0;

    // Scoreboard entry: {last, data}
    logic [PI:0]   exp_q[$];
    logic [NN-1:0] mbuf;
    int            mfill = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: samples just after the falling edge, once the driver
    // has settled its inputs for the coming rising edge.
    always begin
        @(negedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0][PI-1:0]));
                check("out_last", 32'(out_last), 32'(exp_q[0][PI]));
                if (out_ready) begin
                    check("layer_done", 32'(layer_done), 32'(exp_q[0][PI]));
                    if (layer_done) done_cnt++;
                    void'(exp_q.pop_front());
                end
            end
        end else if (layer_done !== 1'b0) begin
            check("layer_done_no_valid", 32'(layer_done), 32'd0);
        end
    end

    task automatic send(input logic [PN-1:0] d, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("in_ready_gap", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            mbuf[mfill +: PN] = d;
            mfill += PN;
            if (mfill == NN) begin
                for (int b = 0; b < NN / PI; b++) begin
                    exp_q.push_back({(b == NN / PI - 1), mbuf[b*PI +: PI]});
                end
                mfill = 0;
                layers_exp++;
                @(negedge clk);
                #1;
                check("fill_to_valid_latency", 32'(out_valid), 32'd1);
            end
        end
    endtask

    task automatic send_layer(input logic [NN-1:0] v, input int gap);
        for (int g = 0; g < NN / PN; g++) begin
            send(v[g*PN +: PN], gap);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #2;
        check("bubble_out_valid", 32'(out_valid), 32'd0);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic pack: 01,10,11,00 -> 8'h39
        send_layer(8'h39, 0);
        wait_drain();

        // Same data with two idle cycles between beats
        send_layer(8'h39, 2);
        wait_drain();

        // Backpressure with ignored input during DRAIN
        out_ready = 1'b0;
        send_layer(8'h39, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 2'b11;
            #1;
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'h9);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        // Next layer must not see the ignored 2'b11 beats
        send_layer(8'hC6, 0);
        wait_drain();

        // Reset mid-fill discards partial layer
        send(2'b11, 0);
        send(2'b11, 0);
        @(negedge clk);
        rst   = 1'b1;
        mfill = 0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        send_layer(8'h40, 0);
        wait_drain();

        // Back-to-back layers A then B
        send_layer(8'h39, 0);
        send_layer(8'hC6, 0);
        wait_drain();

        repeat (3) @(negedge clk);
        check("layer_done_count", 32'(done_cnt), 32'(layers_exp));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
